// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI status types, byte-class limits and parser state encoding
package midi_pkg;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON = 4'h9;
  localparam logic [3:0] PROG_CHANGE = 4'hC;
  localparam logic [3:0] CHAN_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH_BEND = 4'hE;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;
  localparam logic [7:0] SYSTEM_MIN = 8'hF0;
  localparam logic [13:0] PITCH_BEND_CENTER = 14'h2000;
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, DISCARD} state_t;
  function automatic logic [1:0] msg_data_len(input logic [3:0] typ);
    return (typ == PROG_CHANGE || typ == CHAN_PRESSURE) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/midi_note_decoder.sv
// midi_note_decoder: MIDI byte stream to single-voice note/gate, last-note-wins.
// Define MIDI_PITCH_BEND_EN to add the pitch_bend output.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter logic [7:0] RESET_NOTE = 8'd60,
  parameter bit VEL_ZERO_IS_OFF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [3:0]  channel,
  input  logic        omni,
  output logic [7:0]  note,
`ifdef MIDI_PITCH_BEND_EN
  output logic [13:0] pitch_bend,
`endif
  output logic        gate,
  output logic [6:0]  velocity,
  output logic        note_on_pulse
);
  state_t state;
  logic [3:0] typ;
  logic match;
  logic [6:0] d1;
  logic is_rt, is_sys, vel_zero, is_on, is_off;
  always_comb begin
    is_rt = rx_data >= REALTIME_MIN;
    is_sys = rx_data >= SYSTEM_MIN && !is_rt;
    vel_zero = rx_data[6:0] == 7'd0;
    is_on = typ == NOTE_ON && (!vel_zero || !VEL_ZERO_IS_OFF);
    is_off = typ == NOTE_OFF || (typ == NOTE_ON && vel_zero && VEL_ZERO_IS_OFF);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      typ <= 4'h0;
      match <= 1'b0;
      d1 <= 7'd0;
      note <= RESET_NOTE;
      gate <= 1'b0;
      velocity <= 7'd0;
      note_on_pulse <= 1'b0;
`ifdef MIDI_PITCH_BEND_EN
      pitch_bend <= PITCH_BEND_CENTER;
`endif
    end else begin
      note_on_pulse <= 1'b0;
      if (rx_valid && !is_rt) begin
        if (is_sys) begin
          state <= DISCARD;
        end else if (rx_data[7]) begin
          typ <= rx_data[7:4];
          match <= omni || rx_data[3:0] == channel;
          state <= WAIT_D1;
        end else if (state == WAIT_D1) begin
          d1 <= rx_data[6:0];
          state <= msg_data_len(typ) == 2'd1 ? WAIT_D1 : WAIT_D2;
        end else if (state == WAIT_D2) begin
          state <= WAIT_D1;
          if (match && is_on) begin
            note <= {1'b0, d1};
            velocity <= rx_data[6:0];
            gate <= 1'b1;
            note_on_pulse <= 1'b1;
          end else if (match && is_off && gate && d1 == note[6:0]) begin
            gate <= 1'b0;
          end
`ifdef MIDI_PITCH_BEND_EN
          if (match && typ == PITCH_BEND) pitch_bend <= {rx_data[6:0], d1};
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: directed byte sequences with a queue of expected output snapshots
module tb_midi_note_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [3:0] channel = 4'd0;
  logic omni = 1'b0;
  logic [7:0] note;
  logic gate;
  logic [6:0] velocity;
  logic note_on_pulse;
  logic [13:0] pb_obs;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] n;
    logic g;
    logic [6:0] v;
    logic p;
    logic [13:0] pb;
    string tag;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
`ifdef MIDI_PITCH_BEND_EN
  logic [13:0] pitch_bend;
  assign pb_obs = pitch_bend;
`else
  assign pb_obs = 14'h2000;
`endif
  midi_note_decoder dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .channel(channel), .omni(omni), .note(note),
`ifdef MIDI_PITCH_BEND_EN
    .pitch_bend(pitch_bend),
`endif
    .gate(gate), .velocity(velocity), .note_on_pulse(note_on_pulse)
  );
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic push(input string tag, input logic [7:0] n, input logic g, input logic [6:0] v,
                      input logic p, input logic [13:0] pb);
    exp_t e;
    e.tag = tag; e.n = n; e.g = g; e.v = v; e.p = p; e.pb = pb;
    q.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: got 0 entries, expected at least 1");
    end
    if (q.size() == 0) return;
    e = q.pop_front();
    assert (note === e.n) else begin
      errors++; $error("FAIL %s note: got %0h expected %0h", e.tag, note, e.n);
    end
    checks++;
    assert (gate === e.g) else begin
      errors++; $error("FAIL %s gate: got %0b expected %0b", e.tag, gate, e.g);
    end
    checks++;
    assert (velocity === e.v) else begin
      errors++; $error("FAIL %s velocity: got %0d expected %0d", e.tag, velocity, e.v);
    end
    checks++;
    assert (note_on_pulse === e.p) else begin
      errors++; $error("FAIL %s pulse: got %0b expected %0b", e.tag, note_on_pulse, e.p);
    end
    checks++;
    assert (pb_obs === e.pb) else begin
      errors++; $error("FAIL %s pitch_bend: got %0h expected %0h", e.tag, pb_obs, e.pb);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    push("reset", 8'd60, 0, 0, 0, 14'h2000); check();
    send(8'h90); send(8'h3C); push("on_3c", 8'h3C, 1, 100, 1, 14'h2000); send(8'h64); check();
    push("pulse_drop", 8'h3C, 1, 100, 0, 14'h2000); @(negedge clk); check();
    send(8'h90); send(8'h40); push("legato_40", 8'h40, 1, 80, 1, 14'h2000); send(8'h50); check();
    send(8'h80); send(8'h3C); push("stale_off", 8'h40, 1, 80, 0, 14'h2000); send(8'h00); check();
    send(8'h40); push("running_off", 8'h40, 0, 80, 0, 14'h2000); send(8'h00); check();
    send(8'h90); push("rt_mid", 8'h40, 0, 80, 0, 14'h2000); send(8'hF8); check();
    send(8'h3C); send(8'hFE); push("rt_on", 8'h3C, 1, 100, 1, 14'h2000); send(8'h64); check();
    send(8'h80); send(8'h3C); push("off_3c", 8'h3C, 0, 100, 0, 14'h2000); send(8'h00); check();
    send(8'h91); send(8'h3C); push("chan_filter", 8'h3C, 0, 100, 0, 14'h2000); send(8'h64); check();
    omni = 1'b1;
    send(8'h91); send(8'h3C); push("omni_on", 8'h3C, 1, 100, 1, 14'h2000); send(8'h64); check();
    omni = 1'b0;
    send(8'hF0); send(8'h45); send(8'h64); send(8'hF7); send(8'h45);
    push("sysex", 8'h3C, 1, 100, 0, 14'h2000); send(8'h64); check();
    send(8'h90); send(8'h3C); send(8'h90); send(8'h47);
    push("abort_restart", 8'h47, 1, 90, 1, 14'h2000); send(8'h5A); check();
    send(8'h47); push("vel0_off", 8'h47, 0, 90, 0, 14'h2000); send(8'h00); check();
    send(8'hC0); send(8'h05); send(8'h3C);
    push("prog_change", 8'h47, 0, 90, 0, 14'h2000); send(8'h64); check();
    send(8'h90); send(8'h3C);
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    push("reset_mid", 8'd60, 0, 0, 0, 14'h2000); send(8'h64); check();
    send(8'hE0); send(8'h7F);
`ifdef MIDI_PITCH_BEND_EN
    push("bend_max", 8'd60, 0, 0, 0, 14'h3FFF); send(8'h7F); check();
    send(8'h3C); push("bend_running", 8'd60, 0, 0, 0, 14'h323C); send(8'h64); check();
`else
    push("bend_max", 8'd60, 0, 0, 0, 14'h2000); send(8'h7F); check();
    send(8'h3C); push("bend_running", 8'd60, 0, 0, 0, 14'h2000); send(8'h64); check();
`endif
    checks++;
    assert (q.size() == 0) else begin
      errors++; $error("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
